instr_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the 8-bit single-cycle cpu core.
- Assembles each 16-bit instruction from two byte reads of a byte-wide, variable-latency instruction memory.
- Presents the instruction on Iin and pulses EN_L low for exactly one cycle per instruction. The cpu commits (PC <= NextPC, register/memory writes) only in that cycle.
- The NextPC returned by the cpu is captured as the next fetch address.

---
 rtl/instr_fetch_if.sv | 22 ++
 rtl/instr_fetch.sv | 97 +++++++++
 tb/tb_instr_fetch.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Byte-wide instruction memory read port: the fetch stage drives the request,
// the memory answers with a one-cycle MEM_RDY strobe carrying MEM_DATA.
interface instr_fetch_if;
    logic [7:0] MEM_ADDR;
    logic       MEM_RD;
    logic [7:0] MEM_DATA;
    logic       MEM_RDY;

    modport master (
        output MEM_ADDR,
        output MEM_RD,
        input  MEM_DATA,
        input  MEM_RDY
    );

    modport slave (
        input  MEM_ADDR,
        input  MEM_RD,
        output MEM_DATA,
        output MEM_RDY
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: builds a big-endian 16-bit instruction from two byte
// reads and hands it to the cpu with a one-cycle active-low commit enable.
module instr_fetch #(
    parameter logic [7:0]  RESET_PC  = 8'h00,
    parameter int          TIMEOUT   = 15,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [7:0]         NextPC,
    instr_fetch_if.master      mem,
    output logic [15:0]        Iin,
    output logic               EN_L,
    output logic [7:0]         FA,
    output logic               FETCH_ERR
);

    typedef enum logic [1:0] {
        FETCH_HI = 2'd0,
        FETCH_LO = 2'd1,
        ISSUE    = 2'd2
    } state_t;

    // Abort fires at the edge ending the TIMEOUT-th cycle spent without MEM_RDY.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] hi_buf;
    logic [7:0] wait_cnt;
    logic       timed_out;

    assign timed_out = (wait_cnt == WAIT_LAST) && !mem.MEM_RDY;

    // Memory request decoded straight from state; ISSUE idles the bus at FA.
    assign mem.MEM_RD   = (state != ISSUE);
    assign mem.MEM_ADDR = (state == FETCH_LO) ? 8'(FA + 8'd1) : FA;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= FETCH_HI;
            FA        <= RESET_PC;
            Iin       <= 16'h0000;
            EN_L      <= 1'b1;
            FETCH_ERR <= 1'b0;
            wait_cnt  <= 8'd0;
        end else begin
            case (state)
                FETCH_HI: begin
                    if (mem.MEM_RDY) begin
                        hi_buf   <= mem.MEM_DATA;
                        wait_cnt <= 8'd0;
                        state    <= FETCH_LO;
                    end else if (timed_out) begin
                        Iin       <= NOP_INSTR;
                        FETCH_ERR <= 1'b1;
                        EN_L      <= 1'b0;
                        wait_cnt  <= 8'd0;
                        state     <= ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                FETCH_LO: begin
                    if (mem.MEM_RDY) begin
                        Iin      <= {hi_buf, mem.MEM_DATA};
                        EN_L     <= 1'b0;
                        wait_cnt <= 8'd0;
                        state    <= ISSUE;
                    end else if (timed_out) begin
                        Iin       <= NOP_INSTR;
                        FETCH_ERR <= 1'b1;
                        EN_L      <= 1'b0;
                        wait_cnt  <= 8'd0;
                        state     <= ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                ISSUE: begin
                    // The cpu commits this cycle; its NextPC becomes the next fetch.
                    FA    <= NextPC;
                    EN_L  <= 1'b1;
                    state <= FETCH_HI;
                end

                default: begin
                    EN_L     <= 1'b1;
                    wait_cnt <= 8'd0;
                    state    <= FETCH_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: the bench plays both memory and cpu,
// driving MEM_RDY/MEM_DATA/NextPC cycle by cycle.
module tb_instr_fetch;

    logic        CLK;
    logic        RESET;
    logic [7:0]  NextPC;
    logic [15:0] Iin;
    logic        EN_L;
    logic [7:0]  FA;
    logic        FETCH_ERR;

    int tests  = 0;
    int failed = 0;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC  (8'h00),
        .TIMEOUT   (15),
        .NOP_INSTR (16'h0000)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .NextPC    (NextPC),
        .mem       (bus),
        .Iin       (Iin),
        .EN_L      (EN_L),
        .FA        (FA),
        .FETCH_ERR (FETCH_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RESET        = 1'b1;
        NextPC       = 8'h00;
        bus.MEM_RDY  = 1'b0;
        bus.MEM_DATA = 8'h00;

        // Reset state
        cyc();
        check("rst_fa",   32'(FA), 32'h00);
        check("rst_iin",  32'(Iin), 32'h0000);
        check("rst_enl",  32'(EN_L), 32'h1);
        check("rst_err",  32'(FETCH_ERR), 32'h0);
        check("rst_rd",   32'(bus.MEM_RD), 32'h1);
        check("rst_addr", 32'(bus.MEM_ADDR), 32'h00);
        RESET = 1'b0;

        // Zero-wait fetch at 00: 2A 45
        check("zw_addr_hi", 32'(bus.MEM_ADDR), 32'h00);
        bus.MEM_RDY = 1'b1; bus.MEM_DATA = 8'h2A;
        cyc();
        check("zw_addr_lo", 32'(bus.MEM_ADDR), 32'h01);
        check("zw_enl_lo",  32'(EN_L), 32'h1);
        bus.MEM_DATA = 8'h45;
        cyc();
        check("zw_enl_issue", 32'(EN_L), 32'h0);
        check("zw_iin",       32'(Iin), 32'h2A45);
        check("zw_rd_issue",  32'(bus.MEM_RD), 32'h0);
        check("zw_addr_issue", 32'(bus.MEM_ADDR), 32'h00);
        bus.MEM_RDY = 1'b0; NextPC = 8'h02;
        cyc();
        check("zw_fa_next",  32'(FA), 32'h02);
        check("zw_enl_next", 32'(EN_L), 32'h1);

        // Wait states: 4 idle cycles per byte, fetch at 02: C3 3C
        for (int k = 0; k < 4; k++) begin
            check("ws_hi_rd",   32'(bus.MEM_RD), 32'h1);
            check("ws_hi_addr", 32'(bus.MEM_ADDR), 32'h02);
            check("ws_hi_enl",  32'(EN_L), 32'h1);
            check("ws_hi_iin",  32'(Iin), 32'h2A45);
            cyc();
        end
        check("ws_hi_addr4", 32'(bus.MEM_ADDR), 32'h02);
        bus.MEM_RDY = 1'b1; bus.MEM_DATA = 8'hC3;
        cyc();
        bus.MEM_RDY = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("ws_lo_rd",   32'(bus.MEM_RD), 32'h1);
            check("ws_lo_addr", 32'(bus.MEM_ADDR), 32'h03);
            check("ws_lo_enl",  32'(EN_L), 32'h1);
            check("ws_lo_iin",  32'(Iin), 32'h2A45);
            cyc();
        end
        check("ws_lo_addr4", 32'(bus.MEM_ADDR), 32'h03);
        bus.MEM_RDY = 1'b1; bus.MEM_DATA = 8'h3C;
        cyc();
        check("ws_enl_issue", 32'(EN_L), 32'h0);
        check("ws_iin",       32'(Iin), 32'hC33C);
        bus.MEM_RDY = 1'b0; NextPC = 8'hFF;
        cyc();
        check("ws_enl_once", 32'(EN_L), 32'h1);
        check("ws_fa_next",  32'(FA), 32'hFF);

        // Branch to FF with address wrap: FF->12, 00->34
        check("br_addr_hi", 32'(bus.MEM_ADDR), 32'hFF);
        bus.MEM_RDY = 1'b1; bus.MEM_DATA = 8'h12;
        cyc();
        check("br_addr_lo", 32'(bus.MEM_ADDR), 32'h00);
        bus.MEM_DATA = 8'h34;
        cyc();
        check("br_enl", 32'(EN_L), 32'h0);
        check("br_iin", 32'(Iin), 32'h1234);
        bus.MEM_RDY = 1'b0; NextPC = 8'h10;
        cyc();
        check("br_fa_next", 32'(FA), 32'h10);

        // Timeout on the low byte at 10
        bus.MEM_RDY = 1'b1; bus.MEM_DATA = 8'h77;
        cyc();
        bus.MEM_RDY = 1'b0;
        for (int k = 0; k < 15; k++) begin
            check("to_wait_enl", 32'(EN_L), 32'h1);
            check("to_wait_rd",  32'(bus.MEM_RD), 32'h1);
            check("to_wait_err", 32'(FETCH_ERR), 32'h0);
            check("to_wait_addr", 32'(bus.MEM_ADDR), 32'h11);
            cyc();
        end
        check("to_enl", 32'(EN_L), 32'h0);
        check("to_iin", 32'(Iin), 32'h0000);
        check("to_err", 32'(FETCH_ERR), 32'h1);
        check("to_rd",  32'(bus.MEM_RD), 32'h0);
        NextPC = 8'h12;
        cyc();
        check("to_fa_next",  32'(FA), 32'h12);
        check("to_enl_next", 32'(EN_L), 32'h1);
        check("to_err_hold", 32'(FETCH_ERR), 32'h1);

        // Good fetch after timeout keeps the sticky error
        bus.MEM_RDY = 1'b1; bus.MEM_DATA = 8'h5A;
        cyc();
        bus.MEM_DATA = 8'hA5;
        cyc();
        check("post_to_iin", 32'(Iin), 32'h5AA5);
        check("post_to_enl", 32'(EN_L), 32'h0);
        check("post_to_err", 32'(FETCH_ERR), 32'h1);
        bus.MEM_RDY = 1'b0; NextPC = 8'h14;
        cyc();

        // Reset during FETCH_LO with a coincident MEM_RDY
        bus.MEM_RDY = 1'b1; bus.MEM_DATA = 8'h99;
        cyc();
        RESET = 1'b1; bus.MEM_DATA = 8'hEE;
        cyc();
        check("mr_fa",   32'(FA), 32'h00);
        check("mr_addr", 32'(bus.MEM_ADDR), 32'h00);
        check("mr_rd",   32'(bus.MEM_RD), 32'h1);
        check("mr_enl",  32'(EN_L), 32'h1);
        check("mr_iin",  32'(Iin), 32'h0000);
        check("mr_err",  32'(FETCH_ERR), 32'h0);
        RESET = 1'b0; bus.MEM_RDY = 1'b0;
        cyc();
        check("mr_still_hi", 32'(bus.MEM_ADDR), 32'h00);
        check("mr_iin_hold", 32'(Iin), 32'h0000);

        // Timeout race: MEM_RDY on the 15th waiting cycle of the low byte
        bus.MEM_RDY = 1'b1; bus.MEM_DATA = 8'h6B;
        cyc();
        bus.MEM_RDY = 1'b0;
        for (int k = 0; k < 14; k++) cyc();
        check("race_enl_wait", 32'(EN_L), 32'h1);
        check("race_addr",     32'(bus.MEM_ADDR), 32'h01);
        bus.MEM_RDY = 1'b1; bus.MEM_DATA = 8'hC0;
        cyc();
        check("race_enl", 32'(EN_L), 32'h0);
        check("race_iin", 32'(Iin), 32'h6BC0);
        check("race_err", 32'(FETCH_ERR), 32'h0);

        // MEM_RDY during ISSUE (MEM_RD low) must be ignored
        bus.MEM_DATA = 8'hFF; NextPC = 8'h40;
        cyc();
        bus.MEM_RDY = 1'b0;
        check("ign_fa",   32'(FA), 32'h40);
        check("ign_addr", 32'(bus.MEM_ADDR), 32'h40);
        check("ign_enl",  32'(EN_L), 32'h1);
        cyc();
        check("ign_still_hi", 32'(bus.MEM_ADDR), 32'h40);
        check("ign_iin",      32'(Iin), 32'h6BC0);
        check("ign_err",      32'(FETCH_ERR), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
